shadow_ctx_stacker: RTL



---
 rtl/shadow_ctx_stacker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/shadow_ctx_stacker.sv
// Spills the 16-word interrupt shadow bank to a stack frame and restores it
// into the architectural registers, finishing a restore by popping sp.
module shadow_ctx_stacker #(
  parameter int XLEN           = 64,
  parameter int NUM_SHADOW     = 16,
  parameter int BYTES_PER_WORD = XLEN / 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            spill_req_i,
  input  logic            restore_req_i,
  input  logic [XLEN-1:0] base_sp_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [3:0]      shadow_raddr_o,
  input  logic [XLEN-1:0] shadow_rdata_i,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o
);

  typedef enum logic [2:0] {
    IDLE, SPILL, RD_REQ, RD_WAIT, SP_FIX, DONE
  } state_e;

  // Frame slot k -> architectural register: ra, t0-t2, a0-a7, t3-t6.
  localparam logic [15:0][4:0] RF_MAP = {
    5'd31, 5'd30, 5'd29, 5'd28, 5'd17, 5'd16, 5'd15, 5'd14,
    5'd13, 5'd12, 5'd11, 5'd10, 5'd7,  5'd6,  5'd5,  5'd1
  };
  localparam logic [3:0] LAST_K = 4'(NUM_SHADOW - 1);

  state_e          state_reg, state_next;
  logic [3:0]      k_reg, k_next;
  logic [XLEN-1:0] base_reg, base_next;
  logic [XLEN-1:0] word_addr;
  logic [XLEN-1:0] frame_top;

  // Both sums wrap modulo 2^XLEN by construction.
  assign word_addr = base_reg + XLEN'(k_reg) * XLEN'(BYTES_PER_WORD);
  assign frame_top = base_reg + XLEN'(NUM_SHADOW * BYTES_PER_WORD);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      base_reg  <= base_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    base_next      = base_reg;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    shadow_raddr_o = '0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    rf_we_o        = 1'b0;
    rf_waddr_o     = '0;
    rf_wdata_o     = '0;

    case (state_reg)
      IDLE: begin
        // Spill has priority; a simultaneous restore request is dropped.
        if (spill_req_i) begin
          base_next  = base_sp_i;
          k_next     = '0;
          state_next = SPILL;
        end else if (restore_req_i) begin
          base_next  = base_sp_i;
          k_next     = '0;
          state_next = RD_REQ;
        end
      end
      SPILL: begin
        busy_o         = 1'b1;
        mem_req_o      = 1'b1;
        mem_we_o       = 1'b1;
        shadow_raddr_o = k_reg;
        mem_addr_o     = word_addr;
        mem_wdata_o    = shadow_rdata_i;
        if (mem_gnt_i) begin
          if (k_reg == LAST_K) state_next = DONE;
          else                 k_next     = k_reg + 4'd1;
        end
      end
      RD_REQ: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = word_addr;
        if (mem_gnt_i) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        busy_o = 1'b1;
        if (mem_rvalid_i) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = RF_MAP[k_reg];
          rf_wdata_o = mem_rdata_i;
          if (k_reg == LAST_K) begin
            state_next = SP_FIX;
          end else begin
            k_next     = k_reg + 4'd1;
            state_next = RD_REQ;
          end
        end
      end
      SP_FIX: begin
        busy_o     = 1'b1;
        rf_we_o    = 1'b1;
        rf_waddr_o = 5'd2;
        rf_wdata_o = frame_top;
        state_next = DONE;
      end
      DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
